// File: rtl/hb_detect.sv
// rtl/hb_detect.sv - ECG heartbeat detector with adaptive threshold and RR interval
module hb_detect #(
  parameter logic [11:0] THRESH_MIN = 12'd1024,
  parameter logic [11:0] HYST       = 12'd64,
  parameter logic [8:0]  REFRACTORY = 9'd100,
  parameter logic [7:0]  MAX_TRACK  = 8'd40,
  parameter logic [11:0] AVG_INIT   = 12'd2048
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [11:0] sample,
  output logic        heartbeat_detect,
  output logic [15:0] rr_interval,
  output logic        rr_valid,
  output logic [11:0] threshold,
  output logic [15:0] beat_count
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRACK   = 2'd1,
    REFRACT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] avg_q;
  logic [11:0] peak_q, peak_d;
  logic [7:0]  track_cnt_q, track_cnt_d;
  logic [8:0]  refr_cnt_q, refr_cnt_d;
  logic [15:0] since_cnt_q;
  logic        first_q;
  logic        beat;

  logic [13:0] thr_sum;
  logic [12:0] avg_sum;
  logic [11:0] avg_next;
  logic [15:0] since_inc;
  logic [7:0]  track_cnt_inc;
  logic        fall_hit;

  // Threshold is 3/4 of the running peak average, floored at THRESH_MIN.
  assign thr_sum   = {3'b000, avg_q[11:1]} + {4'b0000, avg_q[11:2]};
  assign threshold = (thr_sum[13:12] != 2'b00) ? 12'hFFF :
                     (thr_sum[11:0] > THRESH_MIN) ? thr_sum[11:0] : THRESH_MIN;

  // Average moves 1/8 of the way towards the peak that just produced a beat.
  assign avg_sum  = {1'b0, avg_q} - {4'b0000, avg_q[11:3]} + {4'b0000, peak_d[11:3]};
  assign avg_next = avg_sum[12] ? 12'hFFF : avg_sum[11:0];

  assign since_inc     = (since_cnt_q == 16'hFFFF) ? 16'hFFFF : since_cnt_q + 16'd1;
  assign track_cnt_inc = track_cnt_q + 8'd1;
  // A confirmed fall needs the peak to be at least HYST so the subtraction cannot wrap.
  assign fall_hit      = (peak_q >= HYST) && (sample < (peak_q - HYST));

  // Next-state and beat decision, evaluated only for qualified samples.
  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    track_cnt_d = track_cnt_q;
    refr_cnt_d  = refr_cnt_q;
    beat        = 1'b0;
    if (sample_valid) begin
      case (state_q)
        ARMED: begin
          if (sample > threshold) begin
            state_d     = TRACK;
            peak_d      = sample;
            track_cnt_d = 8'd1;
          end
        end
        TRACK: begin
          if (sample >= peak_q) peak_d = sample;
          track_cnt_d = track_cnt_inc;
          if (fall_hit || (track_cnt_inc >= MAX_TRACK)) begin
            beat       = 1'b1;
            state_d    = REFRACT;
            refr_cnt_d = REFRACTORY;
          end
        end
        REFRACT: begin
          if (refr_cnt_q <= 9'd1) begin
            state_d    = ARMED;
            refr_cnt_d = 9'd0;
          end else begin
            refr_cnt_d = refr_cnt_q - 9'd1;
          end
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // State, tracking counters, running average and registered beat outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ARMED;
      avg_q            <= AVG_INIT;
      peak_q           <= 12'd0;
      track_cnt_q      <= 8'd0;
      refr_cnt_q       <= 9'd0;
      since_cnt_q      <= 16'd0;
      first_q          <= 1'b1;
      heartbeat_detect <= 1'b0;
      rr_valid         <= 1'b0;
      rr_interval      <= 16'd0;
      beat_count       <= 16'd0;
    end else begin
      heartbeat_detect <= beat;
      rr_valid         <= beat && !first_q;
      state_q          <= state_d;
      peak_q           <= peak_d;
      track_cnt_q      <= track_cnt_d;
      refr_cnt_q       <= refr_cnt_d;
      if (sample_valid) begin
        since_cnt_q <= beat ? 16'd0 : since_inc;
      end
      if (beat) begin
        avg_q      <= avg_next;
        beat_count <= beat_count + 16'd1;
        first_q    <= 1'b0;
        // The first beat has no predecessor, so there is no interval to report.
        if (!first_q) rr_interval <= since_inc;
      end
    end
  end

endmodule

// File: tb/tb_hb_detect.sv
// tb/tb_hb_detect.sv - scoreboard testbench for hb_detect
module tb_hb_detect;

  logic        clock;
  logic        reset_n;
  logic        sample_valid;
  logic [11:0] sample;
  logic        heartbeat_detect;
  logic [15:0] rr_interval;
  logic        rr_valid;
  logic [11:0] threshold;
  logic [15:0] beat_count;

  hb_detect dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .sample_valid     (sample_valid),
    .sample           (sample),
    .heartbeat_detect (heartbeat_detect),
    .rr_interval      (rr_interval),
    .rr_valid         (rr_valid),
    .threshold        (threshold),
    .beat_count       (beat_count)
  );

  typedef struct {
    int unsigned due;
    logic [15:0] bc;
    logic        rv;
    logic [15:0] rr;
    logic [11:0] thr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        prev_hb = 1'b0;

  initial clock = 1'b0;
  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Rising-edge counter used for pulse latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic expect_beat(input logic [15:0] bc, input logic rv,
                             input logic [15:0] rr, input logic [11:0] thr);
    exp_t x;
    x.due = cyc + 1;
    x.bc  = bc;
    x.rv  = rv;
    x.rr  = rr;
    x.thr = thr;
    sb.push_back(x);
  endtask

  task automatic send(input logic [11:0] v);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every pulse must match the head of the scoreboard; overdue entries are misses.
  always @(negedge clock) begin
    if (reset_n) begin
      if (heartbeat_detect) begin
        check("no_back_to_back", {31'd0, prev_hb}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: pulse at cycle %0d, none expected", cyc);
        end else begin
          e = sb.pop_front();
          check("beat_cycle", cyc, e.due);
          check("beat_count", {16'd0, beat_count}, {16'd0, e.bc});
          check("rr_valid", {31'd0, rr_valid}, {31'd0, e.rv});
          if (e.rv) check("rr_interval", {16'd0, rr_interval}, {16'd0, e.rr});
          check("threshold_after_beat", {20'd0, threshold}, {20'd0, e.thr});
        end
      end else begin
        if (rr_valid) check("rr_valid_without_beat", {31'd0, rr_valid}, 32'd0);
        if (sb.size() > 0 && cyc > sb[0].due) begin
          checks++;
          errors++;
          $display("FAIL missed_beat: expected pulse at cycle %0d, still absent at cycle %0d", sb[0].due, cyc);
          void'(sb.pop_front());
        end
      end
    end
    prev_hb <= heartbeat_detect;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample       = 12'd0;
    repeat (3) @(negedge clock);
    check("reset_hb", {31'd0, heartbeat_detect}, 32'd0);
    check("reset_rr_valid", {31'd0, rr_valid}, 32'd0);
    check("reset_rr_interval", {16'd0, rr_interval}, 32'd0);
    check("reset_beat_count", {16'd0, beat_count}, 32'd0);
    check("reset_threshold", {20'd0, threshold}, 32'd1536);
    reset_n = 1'b1;
    @(negedge clock);

    // Sub-threshold baseline never triggers.
    repeat (50) send(12'd1000);
    idle(3);
    check("baseline_threshold", {20'd0, threshold}, 32'd1536);

    // First beat: avg 2048 -> 2104, threshold 1578, no interval yet.
    send(12'd1000);
    send(12'd1600);
    send(12'd2000);
    send(12'd2500);
    expect_beat(16'd1, 1'b0, 16'd0, 12'd1578);
    send(12'd2400);

    // Offsets 1..195 after the beat, with a large sample inside the refractory window.
    for (int i = 1; i <= 195; i++) send((i == 50) ? 12'd3000 : 12'd1000);
    send(12'd1000);
    send(12'd1600);
    send(12'd2000);
    send(12'd2500);
    // Second beat at offset 200: avg 2104 -> 2153, threshold 1614.
    expect_beat(16'd2, 1'b1, 16'd200, 12'd1614);
    send(12'd2400);

    // Monotonic ramp: MAX_TRACK ends tracking on the 40th tracked sample (peak 2390).
    repeat (100) send(12'd1000);
    for (int i = 0; i < 60; i++) begin
      if (i == 39) expect_beat(16'd3, 1'b1, 16'd140, 12'd1636);
      send(12'(2000 + 10 * i));
    end

    // Reset in the middle of tracking aborts with no pulse.
    repeat (100) send(12'd1000);
    send(12'd2000);
    send(12'd2500);
    sample_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midtrack_reset_hb", {31'd0, heartbeat_detect}, 32'd0);
    check("midtrack_reset_rr_valid", {31'd0, rr_valid}, 32'd0);
    check("midtrack_reset_beat_count", {16'd0, beat_count}, 32'd0);
    check("midtrack_reset_rr_interval", {16'd0, rr_interval}, 32'd0);
    check("midtrack_reset_threshold", {20'd0, threshold}, 32'd1536);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    repeat (20) send(12'd1000);
    idle(5);
    check("post_reset_beat_count", {16'd0, beat_count}, 32'd0);
    check("post_reset_threshold", {20'd0, threshold}, 32'd1536);
    check("post_reset_rr_interval", {16'd0, rr_interval}, 32'd0);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
